// File: rtl/fmdll_pkg.sv
// Shared DLL tap-path types: tap vector geometry and the index-encoder state enum.
package fmdll_pkg;

  localparam int TAP_N = 16;
  localparam int TAP_W = 4;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCK   = 2'd1,
    CHANGE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/onehot16_classify.sv
// Combinational classifier for one sampled tap vector: legal one-hot, all-zero or
// multi-hot, plus the index of the set bit.
module onehot16_classify
  import fmdll_pkg::*;
(
  input  logic [TAP_N-1:0] s,
  output logic             legal,
  output logic             zero,
  output logic             multi,
  output logic [TAP_W-1:0] idx
);

  logic [TAP_W:0] ones;

  // idx is only meaningful when legal; for multi-hot it holds the highest set bit.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < TAP_N; i++) begin
      ones = ones + {{TAP_W{1'b0}}, s[i]};
      if (s[i]) idx = TAP_W'(i);
    end
  end

  assign zero  = (ones == '0);
  assign legal = (ones == (TAP_W + 1)'(1));
  assign multi = (ones > (TAP_W + 1)'(1));

endmodule

// File: rtl/onehot16_encoder.sv
// Registered, filtered 16-to-4 one-hot encoder for DLL tap readback.
// Define ONEHOT_ENC_SYNC_EN to put a 2-flop synchronizer on T (otherwise one capture flop).
module onehot16_encoder
  import fmdll_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] T,
  input  logic        err_clr,
  output logic [3:0]  Q,
  output logic        q_valid,
  output logic        upd,
  output logic        err,
  output logic        zero,
  output logic [1:0]  state_dbg
);

  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);

  logic [TAP_N-1:0] s;

`ifdef ONEHOT_ENC_SYNC_EN
  logic [TAP_N-1:0] t_meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_meta <= '0;
      s      <= '0;
    end else begin
      t_meta <= T;
      s      <= t_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      s <= T;
    end
  end
`endif

  logic             s_legal;
  logic             s_zero;
  logic             s_multi;
  logic [TAP_W-1:0] s_idx;

  onehot16_classify u_classify (
    .s     (s),
    .legal (s_legal),
    .zero  (s_zero),
    .multi (s_multi),
    .idx   (s_idx)
  );

  enc_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] cand;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] run_next;
  logic             run_done;

  // run_next is the persistence count this sample would produce; cnt is always 0 in
  // LOCK, so a differing index there starts a fresh run of 1.
  always_comb begin
    cnt_inc  = (cnt >= STABLE_V) ? STABLE_V : cnt + CNT_W'(1);
    run_next = (s_idx == cand) ? cnt_inc : CNT_W'(1);
    run_done = (run_next == STABLE_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACQ;
      cnt     <= '0;
      cand    <= '0;
      Q       <= '0;
      q_valid <= 1'b0;
      upd     <= 1'b0;
      err     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      upd  <= 1'b0;
      zero <= s_zero;
      if (en) begin
        if (s_multi) begin
          err <= 1'b1;
        end else if (err_clr) begin
          err <= 1'b0;
        end

        case (state)
          ACQ: begin
            if (s_legal) begin
              cand <= s_idx;
              if (run_done) begin
                Q       <= s_idx;
                q_valid <= 1'b1;
                upd     <= 1'b1;
                cnt     <= '0;
                state   <= LOCK;
              end else begin
                cnt <= run_next;
              end
            end else begin
              cnt <= '0;
            end
          end

          LOCK: begin
            if (s_legal && (s_idx != Q)) begin
              cand <= s_idx;
              if (run_done) begin
                Q   <= s_idx;
                upd <= 1'b1;
              end else begin
                cnt   <= run_next;
                state <= CHANGE;
              end
            end
          end

          CHANGE: begin
            if (!s_legal) begin
              cnt   <= '0;
              state <= LOCK;
            end else if (s_idx == cand) begin
              if (run_done) begin
                Q     <= cand;
                upd   <= 1'b1;
                cnt   <= '0;
                state <= LOCK;
              end else begin
                cnt <= run_next;
              end
            end else if (s_idx == Q) begin
              cnt   <= '0;
              state <= LOCK;
            end else begin
              cand <= s_idx;
              cnt  <= CNT_W'(1);
            end
          end

          default: begin
            cnt   <= '0;
            state <= ACQ;
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_onehot16_encoder.sv
// Bench for onehot16_encoder: a STABLE_CNT=4 instance checked against a hand-derived
// vector table and a run-length reference model, plus a STABLE_CNT=1 instance.
module tb_onehot16_encoder;

`ifdef ONEHOT_ENC_SYNC_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] T = '0;

  always #5 clk = ~clk;

  logic [3:0] q_a, q_b;
  logic       v_a, v_b, u_a, u_b, e_a, e_b, z_a, z_b;
  logic [1:0] st_a, st_b;

  onehot16_encoder #(.STABLE_CNT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .T(T), .err_clr(err_clr),
    .Q(q_a), .q_valid(v_a), .upd(u_a), .err(e_a), .zero(z_a), .state_dbg(st_a)
  );

  onehot16_encoder #(.STABLE_CNT(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .T(T), .err_clr(err_clr),
    .Q(q_b), .q_valid(v_b), .upd(u_b), .err(e_b), .zero(z_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_a = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Q follows a value once it has been seen as the same legal index for stab
  // consecutive enabled samples; any other enabled sample breaks the run.
  int          stab[2] = '{4, 1};
  logic [15:0] m_pipe[P];
  int          m_q[2], m_v[2], m_u[2], m_err[2], run_len[2], run_idx[2];
  int          m_zero;

  function automatic int onehot_pos(input logic [15:0] v);
    int p;
    p = 0;
    for (int k = 0; k < 16; k++) if (v[k]) p = k;
    return p;
  endfunction

  task automatic model_step(input logic [15:0] t, input logic e, input logic c, input logic r);
    logic [15:0] s;
    int pc, x;
    if (!r) begin
      for (int k = 0; k < P; k++) m_pipe[k] = '0;
      for (int i = 0; i < 2; i++) begin
        m_q[i] = 0; m_v[i] = 0; m_u[i] = 0; m_err[i] = 0; run_len[i] = 0; run_idx[i] = 0;
      end
      m_zero = 0;
    end else begin
      s = m_pipe[P-1];
      pc = $countones(s);
      x = onehot_pos(s);
      m_zero = (s == 16'h0) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        m_u[i] = 0;
        if (e) begin
          if (pc >= 2) m_err[i] = 1;
          else if (c) m_err[i] = 0;
          if (pc == 1) begin
            if (run_len[i] > 0 && run_idx[i] == x) run_len[i]++;
            else begin
              run_idx[i] = x;
              run_len[i] = 1;
            end
            if (run_len[i] == stab[i] && (m_v[i] == 0 || x != m_q[i])) begin
              m_q[i] = x; m_v[i] = 1; m_u[i] = 1;
            end
          end else begin
            run_len[i] = 0;
          end
        end
      end
      for (int k = P - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = t;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [15:0] t, input logic e, input logic c, input logic r);
    T = t; en = e; err_clr = c; rst_n = r;
    model_step(t, e, c, r);
    @(posedge clk);
    #1;
    check("b_q", q_b, m_q[1]);
    check("b_valid", v_b, m_v[1]);
    check("b_upd", u_b, m_u[1]);
    check("b_err", e_b, m_err[1]);
    check("b_zero", z_b, m_zero);
    if (chk_a) begin
      check("a_q", q_a, m_q[0]);
      check("a_valid", v_a, m_v[0]);
      check("a_upd", u_a, m_u[0]);
      check("a_err", e_a, m_err[0]);
      check("a_zero", z_a, m_zero);
    end
  endtask

  // ---------------- vector table (STABLE_CNT=4, single capture flop) ----------------
  typedef struct {
    logic [15:0] t;
    logic        en, clr, rst;
    logic [3:0]  q;
    logic        v, u, e, z;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] t, input logic e, input logic c, input logic r,
                              input logic [3:0] q, input logic v, input logic u,
                              input logic er, input logic z, input logic [1:0] st);
    vec_t x;
    x.t = t; x.en = e; x.clr = c; x.rst = r;
    x.q = q; x.v = v; x.u = u; x.e = er; x.z = z; x.st = st;
    tbl.push_back(x);
  endfunction

  initial begin
    logic [15:0] pat;
    int kind, len, a, b;

    // reset, then acquire index 5
    add(16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 5, 1, 1, 0, 0, 1);
    add(16'h0020, 1, 0, 1, 5, 1, 0, 0, 0, 1);
    // index 8 for only three samples: rejected
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 1);
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 2);
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 2);
    add(16'h0020, 1, 0, 1, 5, 1, 0, 0, 0, 2);
    add(16'h0020, 1, 0, 1, 5, 1, 0, 0, 0, 1);
    add(16'h0020, 1, 0, 1, 5, 1, 0, 0, 0, 1);
    // index 8 held: accepted after four samples
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 1);
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 2);
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 2);
    add(16'h0100, 1, 0, 1, 5, 1, 0, 0, 0, 2);
    add(16'h0100, 1, 0, 1, 8, 1, 1, 0, 0, 1);
    add(16'h0100, 1, 0, 1, 8, 1, 0, 0, 0, 1);
    // multi-hot, set-wins-over-clear, then clear alone
    add(16'h0021, 1, 0, 1, 8, 1, 0, 0, 0, 1);
    add(16'h0100, 1, 0, 1, 8, 1, 0, 1, 0, 1);
    add(16'h0021, 1, 0, 1, 8, 1, 0, 1, 0, 1);
    add(16'h0100, 1, 1, 1, 8, 1, 0, 1, 0, 1);
    add(16'h0100, 1, 1, 1, 8, 1, 0, 0, 0, 1);
    // all-zero sample
    add(16'h0000, 1, 0, 1, 8, 1, 0, 0, 0, 1);
    add(16'h0000, 1, 0, 1, 8, 1, 0, 0, 1, 1);
    add(16'h0100, 1, 0, 1, 8, 1, 0, 0, 1, 1);
    add(16'h0100, 1, 0, 1, 8, 1, 0, 0, 0, 1);
    // en low while T moves to index 15, then enabled
    add(16'h8000, 0, 0, 1, 8, 1, 0, 0, 0, 1);
    add(16'h8000, 0, 0, 1, 8, 1, 0, 0, 0, 1);
    add(16'h8000, 0, 0, 1, 8, 1, 0, 0, 0, 1);
    add(16'h8000, 1, 0, 1, 8, 1, 0, 0, 0, 2);
    add(16'h8000, 1, 0, 1, 8, 1, 0, 0, 0, 2);
    add(16'h8000, 1, 0, 1, 8, 1, 0, 0, 0, 2);
    add(16'h8000, 1, 0, 1, 15, 1, 1, 0, 0, 1);
    add(16'h8000, 1, 0, 1, 15, 1, 0, 0, 0, 1);
    // reset in the middle of CHANGE, then reacquire
    add(16'h0020, 1, 0, 1, 15, 1, 0, 0, 0, 1);
    add(16'h0020, 1, 0, 1, 15, 1, 0, 0, 0, 2);
    add(16'h0020, 1, 0, 1, 15, 1, 0, 0, 0, 2);
    add(16'h0020, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(16'h0020, 1, 0, 1, 5, 1, 1, 0, 0, 1);
    add(16'h0020, 1, 0, 1, 5, 1, 0, 0, 0, 1);

    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].t, tbl[i].en, tbl[i].clr, tbl[i].rst);
      check($sformatf("tbl%0d_q", i), q_a, tbl[i].q);
      check($sformatf("tbl%0d_valid", i), v_a, tbl[i].v);
      check($sformatf("tbl%0d_upd", i), u_a, tbl[i].u);
      check($sformatf("tbl%0d_err", i), e_a, tbl[i].e);
      check($sformatf("tbl%0d_zero", i), z_a, tbl[i].z);
      check($sformatf("tbl%0d_state", i), st_a, tbl[i].st);
    end

    // STABLE_CNT=1 instance: a new index is taken on its first sample, pulse once
    step(16'h0010, 1, 0, 1);
    step(16'h0010, 1, 0, 1);
    check("s1_q", q_b, 4);
    check("s1_upd", u_b, 1);
    step(16'h0010, 1, 0, 1);
    check("s1_upd_once", u_b, 0);
    check("s1_state_lock", st_b, 1);

    // randomized phase: both instances against the model
    chk_a = 1'b1;
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 3) * 5;
      b = (a + 1 + $urandom_range(0, 14)) % 16;
      if (kind <= 6) pat = 16'(1) << a;
      else if (kind == 7) pat = '0;
      else if (kind == 8) pat = (16'(1) << a) | (16'(1) << b);
      else pat = 16'($urandom);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        step(pat, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 199) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
